rpn_token_ctrl: RTL and testbench
=================================

RPN_TOKEN_CTRL -- requirements
Module: rpn_token_ctrl

Interface
REQ-001 Parameter RES_TIMEOUT, default 255, max cycles waited for res_ready after a POP.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 rx_data  input  8  received ASCII byte.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-006 num_en  output  1  one-cycle push strobe to rpn datapath.
REQ-007 num  output  16  operand pushed; valid while num_en=1.
REQ-008 op_en  output  1  one-cycle operator strobe to rpn datapath.
REQ-009 op  output  4  operator code: ADD=0, SUB=1, MUL=2, DIV=3, POP=4.
REQ-010 res_value  input  16  result from rpn datapath.
REQ-011 res_ready  input  1  result-valid strobe from rpn datapath.
REQ-012 tx_data  output  8  ASCII byte to UART transmitter.
REQ-013 tx_valid  output  1  tx_data valid; held until accepted.
REQ-014 tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready.
REQ-015 err  output  1  one-cycle pulse on dropped byte or result timeout.

Function
REQ-016 The FSM SHALL have states IDLE, PUSH, OP, WAIT_RES, TX_HEX, TX_CR, TX_LF.
REQ-017 In IDLE, a digit '0'-'9' SHALL update acc = acc*10 + digit, truncated to 16 bits (wrap-around, no saturation), and set pending.
REQ-018 In IDLE, a space with pending=1 SHALL go to PUSH; space with pending=0 SHALL be ignored.
REQ-019 PUSH SHALL assert num_en=1, num=acc for exactly one cycle, clear acc and pending, then return to IDLE or proceed to OP if an operator is latched.
REQ-020 '+', '-', '*', '/' SHALL latch op ADD/SUB/MUL/DIV; if pending, PUSH occurs first so num_en and op_en are in consecutive cycles (num_en first).
REQ-021 '=' or CR (0x0D) SHALL latch op POP, with the same pending-flush rule, then after OP go to WAIT_RES.
REQ-022 OP SHALL assert op_en=1 for exactly one cycle; for non-POP ops return to IDLE.
REQ-023 All other bytes in IDLE (including LF) SHALL be ignored without err.
REQ-024 rx_valid in any state other than IDLE SHALL drop the byte and pulse err.
REQ-025 WAIT_RES SHALL capture res_value on res_ready and go to TX_HEX; after RES_TIMEOUT cycles without res_ready, pulse err and go to IDLE.
REQ-026 res_ready in the same cycle as op_en (POP) SHALL be captured (zero-latency datapath allowed).
REQ-027 TX_HEX SHALL send 4 uppercase hex ASCII digits, most significant nibble first, then TX_CR sends 0x0D, TX_LF sends 0x0A, then IDLE.
REQ-028 Each byte: tx_valid=1 with stable tx_data until the cycle tx_valid&tx_ready; next byte may be presented the following cycle; tx_ready while tx_valid=0 has no effect.
REQ-029 num_en and op_en SHALL never be asserted in the same cycle.
REQ-030 Outside strobe cycles, num and op SHALL hold their last values.

Reset
REQ-031 rst_n low SHALL, asynchronously and regardless of state (including mid-transmit), set state IDLE, acc=0, pending=0, num_en=0, op_en=0, num=0, op=4'hF, tx_valid=0, tx_data=0, err=0, timeout counter=0.
REQ-032 After rst_n rises, the first byte accepted SHALL be one presented on or after the first rising edge with rst_n high.

Verification
REQ-033 Bytes "12 2+2*=" with res_value=0x001C returned 2 cycles after POP -> num_en(12), num_en(2), op_en(ADD), num_en(2), op_en(MUL), op_en(POP); tx bytes '0','0','1','C',0x0D,0x0A.
REQ-034 Bytes "70000 " -> num_en with num=0x1170 (70000 mod 65536 = 4464).
REQ-035 '=' sent, res_ready never asserted -> err pulses exactly once at RES_TIMEOUT cycles, FSM back in IDLE; subsequent "5 " pushes 5.
REQ-036 tx_ready held low 10 cycles during TX_HEX -> tx_valid and tx_data stable all 10 cycles; byte order unchanged; rx byte during TX -> err pulse, byte dropped.
REQ-037 rst_n asserted during TX_HEX after 2 digits sent -> tx_valid=0 immediately, no CR/LF sent; "3 " afterwards pushes 3 with acc cleared.

Source files
------------

// File: rtl/rpn_token_ctrl.sv
// ASCII token controller for an RPN calculator: parses digits/operators
// from a UART byte stream, drives the RPN datapath, sends results as hex.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   rx_data, rx_valid      received byte and one-cycle strobe
//   num_en, num            operand push strobe and value
//   op_en, op              operator strobe and code (ADD..POP)
//   res_value, res_ready   datapath result and strobe
//   tx_data, tx_valid      byte to transmitter, held until tx_ready
//   tx_ready               transmitter accept
//   err                    pulse on dropped byte or result timeout
module rpn_token_ctrl #(
  parameter int unsigned RES_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        num_en,
  output logic [15:0] num,
  output logic        op_en,
  output logic [3:0]  op,
  input  logic [15:0] res_value,
  input  logic        res_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int CW = $clog2(RES_TIMEOUT + 1);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_POP = 4'd4;

  typedef enum logic [2:0] {
    IDLE, PUSH, OP, WAIT_RES, TX_HEX, TX_CR, TX_LF
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   acc_q, acc_d;
  logic          pend_q, pend_d;
  logic [3:0]    opl_q, opl_d;
  logic          opv_q, opv_d;
  logic [15:0]   num_q, num_d;
  logic [3:0]    op_q, op_d;
  logic [15:0]   res_q, res_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          is_digit;
  logic          is_op;
  logic [3:0]    code;
  logic [15:0]   sh;
  logic [3:0]    nib;
  logic [7:0]    hex;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

  always_comb begin
    is_op = 1'b1;
    code  = OP_POP;
    case (rx_data)
      8'h2B:        code = OP_ADD;
      8'h2D:        code = OP_SUB;
      8'h2A:        code = OP_MUL;
      8'h2F:        code = OP_DIV;
      8'h3D, 8'h0D: code = OP_POP;
      default:      is_op = 1'b0;
    endcase
  end

  // Most significant nibble first: shift the selected nibble to the top.
  assign sh  = res_q << {idx_q, 2'b00};
  assign nib = sh[15:12];
  assign hex = (nib < 4'd10) ? (8'h30 + {4'd0, nib})
                             : (8'h37 + {4'd0, nib});

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    opl_d    = opl_q;
    opv_d    = opv_q;
    num_d    = num_q;
    op_d     = op_q;
    res_d    = res_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    num_en   = 1'b0;
    num      = num_q;
    op_en    = 1'b0;
    op       = op_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (is_digit) begin
            acc_d  = {acc_q[12:0], 3'b000} + {acc_q[14:0], 1'b0}
                   + {12'd0, rx_data[3:0]};
            pend_d = 1'b1;
          end else if (rx_data == 8'h20) begin
            if (pend_q) state_d = PUSH;
          end else if (is_op) begin
            opl_d   = code;
            opv_d   = 1'b1;
            state_d = pend_q ? PUSH : OP;
          end
        end
      end
      PUSH: begin
        num_en  = 1'b1;
        num     = acc_q;
        num_d   = acc_q;
        acc_d   = 16'd0;
        pend_d  = 1'b0;
        state_d = opv_q ? OP : IDLE;
      end
      OP: begin
        op_en = 1'b1;
        op    = opl_q;
        op_d  = opl_q;
        opv_d = 1'b0;
        if (opl_q == OP_POP) begin
          // A zero-latency datapath may answer in the op_en cycle.
          if (res_ready) begin
            res_d   = res_value;
            idx_d   = 2'd0;
            state_d = TX_HEX;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RES;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RES: begin
        if (res_ready) begin
          res_d   = res_value;
          idx_d   = 2'd0;
          state_d = TX_HEX;
        end else if (cnt_q == CW'(RES_TIMEOUT - 1)) begin
          err     = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_HEX: begin
        tx_valid = 1'b1;
        tx_data  = hex;
        if (tx_ready) begin
          if (idx_q == 2'd3) state_d = TX_CR;
          else idx_d = idx_q + 2'd1;
        end
      end
      TX_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_d = TX_LF;
      end
      TX_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bytes arriving while busy are dropped.
    if (rx_valid && (state_q != IDLE)) err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 16'd0;
      pend_q  <= 1'b0;
      opl_q   <= OP_POP;
      opv_q   <= 1'b0;
      num_q   <= 16'd0;
      op_q    <= 4'hF;
      res_q   <= 16'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      opl_q   <= opl_d;
      opv_q   <= opv_d;
      num_q   <= num_d;
      op_q    <= op_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rpn_token_ctrl.sv
// Scoreboard bench for rpn_token_ctrl: directed byte streams,
// expected pushes/ops/tx bytes queued and compared on DUT strobes.
module tb_rpn_token_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        num_en;
  logic [15:0] num;
  logic        op_en;
  logic [3:0]  op;
  logic [15:0] res_value = 16'h0000;
  logic        res_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        err;

  rpn_token_ctrl #(.RES_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .num_en(num_en), .num(num),
    .op_en(op_en), .op(op),
    .res_value(res_value), .res_ready(res_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_num[$];
  logic [3:0]  exp_op[$];
  logic [7:0]  exp_tx[$];
  int err_cnt = 0, tx_acc = 0, hold_cnt = 0;
  int cyc = 0, pop_cyc = 0, err_cyc = 0;
  int res_delay = -1;
  logic [15:0] rv = 16'h0000;
  logic prev_hold = 1'b0;
  logic [7:0] prev_d = 8'h00;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every strobe against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (num_en | op_en) chk("strobe_overlap", 32'(num_en & op_en), 0);
      if (num_en) begin
        if (exp_num.size() == 0) chk("num_unexpected", 32'(exp_num.size()), 1);
        else chk("num", num, exp_num.pop_front());
      end
      if (op_en) begin
        if (op == 4'd4) pop_cyc = cyc;
        if (exp_op.size() == 0) chk("op_unexpected", 32'(exp_op.size()), 1);
        else chk("op", op, exp_op.pop_front());
      end
      if (prev_hold) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, prev_d);
      end
      if (tx_valid && tx_ready) begin
        tx_acc++;
        if (exp_tx.size() == 0) chk("tx_unexpected", 32'(exp_tx.size()), 1);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      prev_hold = tx_valid && !tx_ready;
      prev_d = tx_data;
      if (prev_hold) hold_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Datapath model: answers a POP after res_delay cycles.
  initial forever begin
    @(negedge clk);
    if (rst_n && op_en && op == 4'd4 && res_delay >= 0) begin
      repeat (res_delay) @(posedge clk);
      #1 res_value = rv;
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_acc < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("tx_wait", tx_acc, n);
  endtask

  task automatic wait_tx_valid();
    int k = 0;
    while (!tx_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tx_start", tx_valid, 1);
  endtask

  int t0, e0, h0, k;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("rst_num_en", num_en, 0);
    chk("rst_op_en", op_en, 0);
    chk("rst_num", num, 0);
    chk("rst_op", op, 4'hF);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_err", err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // "12 2+2*=" with result 0x001C two cycles after POP
    exp_num.push_back(16'd12);
    exp_num.push_back(16'd2);
    exp_num.push_back(16'd2);
    exp_op.push_back(4'd0);
    exp_op.push_back(4'd2);
    exp_op.push_back(4'd4);
    exp_tx.push_back("0");
    exp_tx.push_back("0");
    exp_tx.push_back("1");
    exp_tx.push_back("C");
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
    res_delay = 2;
    rv = 16'h001C;
    t0 = tx_acc;
    send_str("12 2+2*=");
    wait_tx(t0 + 6);
    chk("t1_num_drain", 32'(exp_num.size()), 0);
    chk("t1_op_drain", 32'(exp_op.size()), 0);
    chk("t1_err", err_cnt, 0);

    // Accumulator wrap
    exp_num.push_back(16'h1170);
    send_str("70000 ");
    chk("t2_num_drain", 32'(exp_num.size()), 0);

    // Result timeout
    res_delay = -1;
    e0 = err_cnt;
    exp_op.push_back(4'd4);
    send("=");
    k = 0;
    while (err_cnt == e0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk("t3_err_once", err_cnt - e0, 1);
    chk("t3_err_latency", err_cyc - pop_cyc, 255);
    repeat (10) @(posedge clk);
    chk("t3_err_still_once", err_cnt - e0, 1);
    exp_num.push_back(16'd5);
    send_str("5 ");
    chk("t3_num_drain", 32'(exp_num.size()), 0);

    // Backpressure during TX_HEX plus a dropped byte
    res_delay = 2;
    rv = 16'hA5F0;
    tx_ready = 1'b0;
    exp_op.push_back(4'd4);
    exp_tx.push_back("A");
    exp_tx.push_back("5");
    exp_tx.push_back("F");
    exp_tx.push_back("0");
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
    t0 = tx_acc;
    e0 = err_cnt;
    h0 = hold_cnt;
    send("=");
    wait_tx_valid();
    repeat (3) @(posedge clk);
    #1 rx_data = "7";
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (6) @(posedge clk);
    chk("t4_no_accept", tx_acc - t0, 0);
    chk("t4_drop_err", err_cnt - e0, 1);
    chk("t4_hold_cycles", 32'((hold_cnt - h0) >= 10), 1);
    #1 tx_ready = 1'b1;
    wait_tx(t0 + 6);
    send(" ");
    repeat (3) @(posedge clk);
    chk("t4_tx_drain", 32'(exp_tx.size()), 0);
    chk("t4_num_drain", 32'(exp_num.size()), 0);

    // Reset in the middle of TX_HEX after two digits
    rv = 16'hBEEF;
    tx_ready = 1'b0;
    exp_op.push_back(4'd4);
    exp_tx.push_back("B");
    exp_tx.push_back("E");
    t0 = tx_acc;
    send("=");
    wait_tx_valid();
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tx_valid_rst", tx_valid, 0);
    chk("t5_tx_data_rst", tx_data, 0);
    chk("t5_op_rst", op, 4'hF);
    chk("t5_num_rst", num, 0);
    chk("t5_two_sent", tx_acc - t0, 2);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    chk("t5_no_more_tx", tx_acc - t0, 2);
    exp_num.push_back(16'd3);
    send_str("3 ");
    chk("t5_num_drain", 32'(exp_num.size()), 0);
    chk("final_op_drain", 32'(exp_op.size()), 0);
    chk("final_tx_drain", 32'(exp_tx.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
